// File: rtl/clock_monitor.sv
// clock_monitor: measures period/high time of a slow synchronized signal and reports lock/timeout
module clock_monitor #(
  parameter int WIDTH      = 32,
  parameter int TIMEOUT    = 1024,
  parameter int EXP_PERIOD = 100,
  parameter int EXP_HIGH   = 50,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);
  typedef enum logic {WAIT_EDGE, MEASURE} state_t;
  localparam logic [WIDTH-1:0] TO = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] TO1 = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] LC = WIDTH'(LOCK_COUNT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH:0] EP = (WIDTH+1)'(EXP_PERIOD);
  localparam logic [WIDTH:0] EH = (WIDTH+1)'(EXP_HIGH);
  localparam logic signed [WIDTH:0] TS = (WIDTH+1)'(TOL);
  state_t state, state_n;
  logic s1, s2, s_d, rise, hit, mv_n, lock_n, to_n;
  logic [WIDTH-1:0] idle_cnt, period_cnt, high_cnt, match_cnt;
  logic [WIDTH-1:0] idle_n, pcnt_n, hcnt_n, match_n, period_n, high_n;
  logic signed [WIDTH:0] dp, dh;
  assign rise = s2 & ~s_d;
  // Differences one bit wider than the counters so they never wrap
  assign dp = $signed({1'b0, period_cnt} - EP);
  assign dh = $signed({1'b0, high_cnt} - EH);
  assign hit = (dp <= TS) && (dp >= -TS) && (dh <= TS) && (dh >= -TS);
  always_comb begin
    state_n = state;
    idle_n = idle_cnt;
    pcnt_n = period_cnt;
    hcnt_n = high_cnt;
    match_n = match_cnt;
    period_n = period;
    high_n = high_time;
    mv_n = 1'b0;
    lock_n = locked;
    to_n = timeout;
    if (state == WAIT_EDGE) begin
      if (rise) begin
        state_n = MEASURE;
        pcnt_n = ONE;
        hcnt_n = ONE;
        idle_n = '0;
      end else begin
        idle_n = (idle_cnt == TO) ? idle_cnt : idle_cnt + ONE;
        to_n = (idle_cnt >= TO1) ? 1'b1 : timeout;
      end
    end else if (rise) begin
      period_n = period_cnt;
      high_n = high_cnt;
      mv_n = 1'b1;
      to_n = 1'b0;
      pcnt_n = ONE;
      hcnt_n = ONE;
      match_n = hit ? ((match_cnt == LC) ? match_cnt : match_cnt + ONE) : '0;
      lock_n = hit && (match_n == LC);
    end else if (period_cnt == TO) begin
      to_n = 1'b1;
      lock_n = 1'b0;
      match_n = '0;
      state_n = WAIT_EDGE;
      idle_n = TO;
    end else begin
      pcnt_n = period_cnt + ONE;
      hcnt_n = high_cnt + WIDTH'(s2);
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      {s1, s2, s_d} <= '0;
      state <= WAIT_EDGE;
      idle_cnt <= '0;
      period_cnt <= '0;
      high_cnt <= '0;
      match_cnt <= '0;
      period <= '0;
      high_time <= '0;
      meas_valid <= 1'b0;
      locked <= 1'b0;
      timeout <= 1'b0;
    end else begin
      {s1, s2, s_d} <= {sig_in, s1, s2};
      state <= state_n;
      idle_cnt <= idle_n;
      period_cnt <= pcnt_n;
      high_cnt <= hcnt_n;
      match_cnt <= match_n;
      period <= period_n;
      high_time <= high_n;
      meas_valid <= mv_n;
      locked <= lock_n;
      timeout <= to_n;
    end
  end
endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: directed checks of measurement, lock, tolerance, timeout and reset behaviour
module tb_clock_monitor;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b0;
  logic [31:0] period, high_time;
  logic meas_valid, locked, timeout;
  int checks = 0;
  int errors = 0;
  int mv_cnt = 0;
  logic [31:0] obs_p = '0, obs_h = '0;
  logic seen_lock = 1'b0, seen_to = 1'b0;
  clock_monitor dut (
    .clk_in(clk_in),
    .rst(rst),
    .sig_in(sig_in),
    .period(period),
    .high_time(high_time),
    .meas_valid(meas_valid),
    .locked(locked),
    .timeout(timeout)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = v;
      @(posedge clk_in);
      #1;
      if (meas_valid) begin
        mv_cnt++;
        obs_p = period;
        obs_h = high_time;
      end
      if (locked) seen_lock = 1'b1;
      if (timeout) seen_to = 1'b1;
    end
  endtask
  task automatic sq(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high"}, high_time, 0);
    chk({tag, "_mv"}, {31'b0, meas_valid}, 0);
    chk({tag, "_locked"}, {31'b0, locked}, 0);
    chk({tag, "_timeout"}, {31'b0, timeout}, 0);
  endtask
  initial begin
    drive(1'b0, 3);
    chk_zero("rst");
    rst = 1'b0;
    // matching 50/50 wave: first rise only arms
    mv_cnt = 0;
    sq(50, 50);
    chk("arm_no_mv", mv_cnt, 0);
    drive(1'b1, 2);
    chk("lat_mv_early", {31'b0, meas_valid}, 0);
    drive(1'b1, 1);
    chk("lat_mv", {31'b0, meas_valid}, 1);
    chk("m1_period", period, 100);
    chk("m1_high", high_time, 50);
    chk("m1_locked", {31'b0, locked}, 0);
    drive(1'b1, 1);
    chk("mv_one_cycle", {31'b0, meas_valid}, 0);
    drive(1'b1, 46);
    drive(1'b0, 50);
    mv_cnt = 0;
    seen_to = 1'b0;
    sq(50, 50);
    sq(50, 50);
    chk("m3_locked", {31'b0, locked}, 0);
    sq(50, 50);
    chk("m4_locked", {31'b0, locked}, 1);
    chk("m4_cnt", mv_cnt, 3);
    chk("m4_period", obs_p, 100);
    chk("m4_high", obs_h, 50);
    chk("m_no_timeout", {31'b0, seen_to}, 0);
    // wrong duty cycle
    sq(75, 25);
    sq(75, 25);
    seen_lock = 1'b0;
    mv_cnt = 0;
    repeat (4) sq(75, 25);
    chk("duty_cnt", mv_cnt, 4);
    chk("duty_period", obs_p, 100);
    chk("duty_high", obs_h, 75);
    chk("duty_never_lock", {31'b0, seen_lock}, 0);
    // tolerance boundary 101/99
    sq(50, 51);
    sq(50, 49);
    sq(50, 51);
    sq(50, 49);
    chk("tol_3_locked", {31'b0, locked}, 0);
    sq(50, 51);
    chk("tol_4_locked", {31'b0, locked}, 1);
    chk("tol_4_period", obs_p, 99);
    sq(50, 52);
    drive(1'b1, 3);
    chk("tol_102_mv", {31'b0, meas_valid}, 1);
    chk("tol_102_period", period, 102);
    chk("tol_102_locked", {31'b0, locked}, 0);
    drive(1'b1, 47);
    drive(1'b0, 51);
    sq(50, 49);
    sq(50, 51);
    sq(50, 49);
    chk("relock_3", {31'b0, locked}, 0);
    sq(50, 51);
    chk("relock_4", {31'b0, locked}, 1);
    // timeout after lock
    drive(1'b1, 3);
    chk("to_last_mv", {31'b0, meas_valid}, 1);
    chk("to_last_period", period, 101);
    drive(1'b1, 47);
    drive(1'b0, 976);
    chk("to_before", {31'b0, timeout}, 0);
    chk("to_before_lock", {31'b0, locked}, 1);
    drive(1'b0, 1);
    chk("to_set", {31'b0, timeout}, 1);
    chk("to_unlock", {31'b0, locked}, 0);
    chk("to_period_hold", period, 101);
    chk("to_high_hold", high_time, 50);
    mv_cnt = 0;
    sq(50, 50);
    chk("to_arm_no_mv", mv_cnt, 0);
    chk("to_arm_still", {31'b0, timeout}, 1);
    drive(1'b1, 3);
    chk("to_resume_mv", {31'b0, meas_valid}, 1);
    chk("to_cleared", {31'b0, timeout}, 0);
    chk("to_resume_period", period, 100);
    drive(1'b1, 47);
    drive(1'b0, 50);
    repeat (3) sq(50, 50);
    chk("pre_rst_locked", {31'b0, locked}, 1);
    // one-cycle reset mid-period
    drive(1'b1, 50);
    drive(1'b0, 20);
    rst = 1'b1;
    drive(1'b0, 1);
    rst = 1'b0;
    chk_zero("rst_mid");
    mv_cnt = 0;
    drive(1'b0, 30);
    sq(50, 50);
    chk("rst_arm_no_mv", mv_cnt, 0);
    drive(1'b1, 3);
    chk("rst_next_mv", {31'b0, meas_valid}, 1);
    chk("rst_next_period", period, 100);
    drive(1'b1, 47);
    drive(1'b0, 50);
    // reset held while toggling, then timeout from reset
    rst = 1'b1;
    mv_cnt = 0;
    for (int i = 0; i < 20; i++) drive(1'(i % 2), 1);
    chk("rst_hold_mv", mv_cnt, 0);
    chk_zero("rst_hold");
    rst = 1'b0;
    drive(1'b0, 1023);
    chk("rst_to_before", {31'b0, timeout}, 0);
    drive(1'b0, 1);
    chk("rst_to_set", {31'b0, timeout}, 1);
    // fast toggling input
    for (int i = 0; i < 10; i++) drive(1'(i % 2 == 0), 1);
    mv_cnt = 0;
    for (int i = 0; i < 20; i++) drive(1'(i % 2 == 0), 1);
    chk("fast_cnt", mv_cnt, 10);
    chk("fast_period", period, 2);
    chk("fast_high", high_time, 1);
    chk("fast_timeout", {31'b0, timeout}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
